lead_one_enc_pipe: RTL

Parametrised, pipelined leading-one encoder for the PE datapath. Accepts one WIDTH-bit word per cycle over a valid/ready handshake and returns the index of the most-significant set bit (or least-significant, selected per transaction), plus a zero flag. It replaces fixed-width combinational priority encoders wherever the encoded word feeds registered PE logic and timing closure needs a two-stage, group-based search.

---
 rtl/lead_one_enc_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lead_one_enc_pipe.sv
// Two-stage, group-based leading-one encoder with valid/ready handshakes on both sides.
// Define LOD_NORM_EN to add the out_norm port, the S1 data register and the normalising shifter.
module lead_one_enc_pipe #(
   parameter  int WIDTH = 16,
   parameter  int GROUP = 4,
   localparam int IW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_lsb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IW-1:0]    out_idx,
`ifdef LOD_NORM_EN
   output logic [WIDTH-1:0] out_norm,
`endif
   output logic             out_zero
);
   localparam int NG = WIDTH / GROUP;
   localparam int LW = $clog2(GROUP);

   logic                  s2_adv;
   logic                  s1_adv;
   logic                  s1_valid_reg;
   logic                  s1_lsb_reg;
   logic [NG-1:0]         s1_any_reg;
   logic [NG-1:0][LW-1:0] s1_idx_reg;
   logic [NG-1:0]         grp_any_next;
   logic [NG-1:0][LW-1:0] grp_idx_next;
   logic                  s2_valid_reg;
   logic [IW-1:0]         out_idx_reg;
   logic [IW-1:0]         out_idx_next;
   logic                  out_zero_reg;
   logic                  out_zero_next;

   assign s2_adv    = !s2_valid_reg || out_ready;
   assign s1_adv    = !s1_valid_reg || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_reg;
   assign out_idx   = out_idx_reg;
   assign out_zero  = out_zero_reg;

   // Stage 1: each group reports whether it holds a one and where its local winner sits.
   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      logic [GROUP-1:0] slice;
      logic [LW-1:0]    lidx;

      assign slice = in_data[gi*GROUP +: GROUP];

      always_comb begin
         lidx = '0;
         if (in_lsb) begin
            for (int b = GROUP - 1; b >= 0; b--) begin
               if (slice[b]) lidx = LW'(b);
            end
         end else begin
            for (int b = 0; b < GROUP; b++) begin
               if (slice[b]) lidx = LW'(b);
            end
         end
      end

      assign grp_any_next[gi] = |slice;
      assign grp_idx_next[gi] = lidx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_lsb_reg   <= 1'b0;
         s1_any_reg   <= '0;
         s1_idx_reg   <= '0;
      end else if (s1_adv) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_lsb_reg <= in_lsb;
            s1_any_reg <= grp_any_next;
            s1_idx_reg <= grp_idx_next;
         end
      end
   end

   // Stage 2: pick the winning group; last assignment in scan order wins.
   always_comb begin
      out_idx_next  = '0;
      out_zero_next = ~|s1_any_reg;
      if (s1_lsb_reg) begin
         for (int g = NG - 1; g >= 0; g--) begin
            if (s1_any_reg[g]) out_idx_next = IW'(g * GROUP) + IW'(s1_idx_reg[g]);
         end
      end else begin
         for (int g = 0; g < NG; g++) begin
            if (s1_any_reg[g]) out_idx_next = IW'(g * GROUP) + IW'(s1_idx_reg[g]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         out_idx_reg  <= '0;
         out_zero_reg <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            out_idx_reg  <= out_idx_next;
            out_zero_reg <= out_zero_next;
         end
      end
   end

`ifdef LOD_NORM_EN
   logic [WIDTH-1:0] s1_data_reg;
   logic [WIDTH-1:0] out_norm_reg;
   logic [WIDTH-1:0] out_norm_next;

   // A zero word shifts to zero in either direction, so no special case is needed.
   always_comb begin
      out_norm_next = '0;
      if (s1_lsb_reg) out_norm_next = s1_data_reg >> out_idx_next;
      else            out_norm_next = s1_data_reg << (IW'(WIDTH - 1) - out_idx_next);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_data_reg  <= '0;
         out_norm_reg <= '0;
      end else begin
         if (s1_adv && in_valid)       s1_data_reg  <= in_data;
         if (s2_adv && s1_valid_reg)   out_norm_reg <= out_norm_next;
      end
   end

   assign out_norm = out_norm_reg;
`endif

endmodule
